// File: rtl/thor2022_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : thor2022_micro_sequencer
//  Description : Expands macro opcodes into micro-op streams from an external
//                combinational micro-code ROM; plain instructions pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module thor2022_micro_sequencer #(
  parameter int MIPW      = 7,
  parameter int MAX_STEPS = 16,
  parameter bit DROP_NOP  = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [47:0]     in_ir_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [MIPW-1:0] micro_ipo,
  output logic [47:0]     micro_ir_o,
  input  logic [MIPW-1:0] next_mip_i,
  input  logic [47:0]     uir_i,
  input  logic [3:0]      incr_i,
  output logic [47:0]     out_ir_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3:0]      out_incr_o,
  output logic            out_micro_o,
  output logic            out_first_o,
  output logic            out_last_o,
  output logic            busy_o,
  output logic            irq_hold_o,
  output logic            err_o
);

  localparam int c_STEPW = $clog2(MAX_STEPS + 1);

  localparam logic [6:0] c_OPC_NOP    = 7'h3F;
  localparam logic [6:0] c_OPC_POP    = 7'h60;
  localparam logic [6:0] c_OPC_POPN   = 7'h61;
  localparam logic [6:0] c_OPC_PUSH   = 7'h62;
  localparam logic [6:0] c_OPC_PUSHN  = 7'h63;
  localparam logic [6:0] c_OPC_LEAVE  = 7'h64;
  localparam logic [6:0] c_OPC_STOO   = 7'h65;
  localparam logic [6:0] c_OPC_ENTER  = 7'h66;
  localparam logic [6:0] c_OPC_DEFCAT = 7'h67;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  state_t              r_state;
  logic [MIPW-1:0]     r_mip;
  logic [c_STEPW-1:0]  r_step;
  logic [47:0]         r_micro_ir;
  logic [47:0]         r_out_ir;
  logic [3:0]          r_out_incr;
  logic                r_out_valid;
  logic                r_out_micro;
  logic                r_out_first;
  logic                r_out_last;
  logic                r_err;

  logic                w_slot_free;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_is_macro;
  logic [MIPW-1:0]     w_entry;
  logic                w_end;
  logic                w_drop;
  logic                w_wdog;

  always_comb begin
    w_is_macro = 1'b1;
    w_entry    = '0;
    case (in_ir_i[6:0])
      c_OPC_POP:    w_entry = MIPW'(1);
      c_OPC_POPN:   w_entry = MIPW'(5);
      c_OPC_PUSH:   w_entry = MIPW'(10);
      c_OPC_PUSHN:  w_entry = MIPW'(15);
      c_OPC_LEAVE:  w_entry = MIPW'(20);
      c_OPC_STOO:   w_entry = MIPW'(28);
      c_OPC_ENTER:  w_entry = MIPW'(32);
      c_OPC_DEFCAT: w_entry = MIPW'(44);
      default:      w_is_macro = 1'b0;
    endcase
  end

  assign w_slot_free = ~r_out_valid | out_ready_i;
  assign w_in_ready  = (r_state == ST_IDLE) & w_slot_free & ~flush_i;
  assign w_accept    = w_in_ready & in_valid_i;
  assign w_end       = (next_mip_i == '0);
  // A dropped NOP is not an emitted op, so it never trips the watchdog.
  assign w_drop      = DROP_NOP & (uir_i[6:0] == c_OPC_NOP) & ~w_end;
  assign w_wdog      = ~w_drop & ~w_end & (r_step == c_STEPW'(MAX_STEPS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_mip       <= '0;
      r_step      <= '0;
      r_micro_ir  <= '0;
      r_out_ir    <= '0;
      r_out_incr  <= '0;
      r_out_valid <= 1'b0;
      r_out_micro <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (flush_i) begin
        r_out_valid <= 1'b0;
        r_state     <= ST_IDLE;
        r_mip       <= '0;
        r_step      <= '0;
      end else if (r_state == ST_IDLE) begin
        if (w_accept && w_is_macro) begin
          r_micro_ir  <= in_ir_i;
          r_mip       <= w_entry;
          r_step      <= '0;
          r_state     <= ST_SEQ;
          r_out_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_ir    <= in_ir_i;
          r_out_valid <= 1'b1;
          r_out_micro <= 1'b0;
          r_out_first <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_incr  <= '0;
        end else if (w_slot_free) begin
          r_out_valid <= 1'b0;
        end
      end else if (w_slot_free) begin
        if (w_drop) begin
          r_mip       <= next_mip_i;
          r_out_valid <= 1'b0;
        end else begin
          r_out_ir    <= uir_i;
          r_out_incr  <= incr_i;
          r_out_valid <= 1'b1;
          r_out_micro <= 1'b1;
          r_out_first <= (r_step == '0);
          r_out_last  <= w_end | w_wdog;
          if (w_end || w_wdog) begin
            r_state <= ST_IDLE;
            r_mip   <= '0;
            r_step  <= '0;
            r_err   <= w_wdog;
          end else begin
            r_mip  <= next_mip_i;
            r_step <= r_step + c_STEPW'(1);
          end
        end
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign micro_ipo   = r_mip;
  assign micro_ir_o  = r_micro_ir;
  assign out_ir_o    = r_out_ir;
  assign out_valid_o = r_out_valid;
  assign out_incr_o  = r_out_incr;
  assign out_micro_o = r_out_micro;
  assign out_first_o = r_out_first;
  assign out_last_o  = r_out_last;
  assign busy_o      = (r_state == ST_SEQ);
  assign irq_hold_o  = (r_state == ST_SEQ) | (r_out_valid & r_out_micro & ~r_out_last);
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_thor2022_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thor2022_micro_sequencer
//  Description : Directed bench for the micro sequencer with a table ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thor2022_micro_sequencer;

  localparam logic [6:0] c_OPC_ADD   = 7'h04;
  localparam logic [6:0] c_OPC_ADDI  = 7'h05;
  localparam logic [6:0] c_OPC_SUBI  = 7'h06;
  localparam logic [6:0] c_OPC_LDH   = 7'h10;
  localparam logic [6:0] c_OPC_STH   = 7'h11;
  localparam logic [6:0] c_OPC_NOP   = 7'h3F;
  localparam logic [6:0] c_OPC_POP   = 7'h60;
  localparam logic [6:0] c_OPC_POPN  = 7'h61;
  localparam logic [6:0] c_OPC_PUSH  = 7'h62;
  localparam logic [6:0] c_OPC_PUSHN = 7'h63;
  localparam logic [6:0] c_OPC_ENTER = 7'h66;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_valid_dn, out_ready, rom_loop;
  logic [47:0] in_ir;
  int          errors = 0;
  int          checks = 0;

  logic        in_ready, out_valid, out_micro, out_first, out_last, busy, irq_hold, err;
  logic [6:0]  micro_ip, next_mip;
  logic [47:0] micro_ir, out_ir, uir;
  logic [3:0]  incr, out_incr;

  logic        in_ready_dn, out_valid_dn, out_micro_dn, out_first_dn, out_last_dn;
  logic        busy_dn, irq_hold_dn, err_dn;
  logic [6:0]  micro_ip_dn, next_mip_dn;
  logic [47:0] micro_ir_dn, out_ir_dn, uir_dn;
  logic [3:0]  incr_dn, out_incr_dn;

  function automatic logic [47:0] mk(input logic [6:0] op, input logic [31:0] tag);
    return {9'd0, tag, op};
  endfunction

  // ROM: {next_mip, uir, incr}; unknown mips give NOP with next 0.
  function automatic logic [58:0] rom(input logic [6:0] mip, input logic lp);
    logic [6:0]  nx;
    logic [47:0] ir;
    logic [3:0]  inc;
    nx = 7'd0; ir = mk(c_OPC_NOP, 0); inc = 4'd0;
    if (mip == 7'd1) begin nx = 7'd2; ir = mk(c_OPC_LDH, 1); inc = 4'd2; end
    else if (mip == 7'd2) begin ir = mk(c_OPC_ADDI, 2); inc = 4'd2; end
    else if (mip == 7'd5) begin nx = 7'd6; ir = mk(c_OPC_LDH, 5); inc = 4'd2; end
    else if (mip == 7'd6 && lp) begin nx = 7'd5; ir = mk(c_OPC_SUBI, 6); inc = 4'd1; end
    else if (mip == 7'd6) begin nx = 7'd7; ir = mk(c_OPC_NOP, 6); end
    else if (mip == 7'd7) begin nx = 7'd8; ir = mk(c_OPC_LDH, 7); inc = 4'd2; end
    else if (mip == 7'd8) begin nx = 7'd9; ir = mk(c_OPC_NOP, 8); end
    else if (mip == 7'd9) begin ir = mk(c_OPC_ADDI, 9); inc = 4'd2; end
    else if ((mip >= 7'd15 && mip <= 7'd18) || (mip >= 7'd32 && mip <= 7'd35)) begin
      nx = mip + 7'd1; ir = mk(c_OPC_STH, {25'd0, mip}); inc = 4'd1;
    end
    else if (mip == 7'd19) begin ir = mk(c_OPC_ADDI, 19); inc = 4'd4; end
    else if (mip == 7'd36) begin ir = mk(c_OPC_SUBI, 36); inc = 4'd3; end
    return {nx, ir, inc};
  endfunction

  assign {next_mip, uir, incr}          = rom(micro_ip, rom_loop);
  assign {next_mip_dn, uir_dn, incr_dn} = rom(micro_ip_dn, rom_loop);

  thor2022_micro_sequencer #(.MIPW(7), .MAX_STEPS(16), .DROP_NOP(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_ir_i(in_ir), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .micro_ipo(micro_ip), .micro_ir_o(micro_ir), .next_mip_i(next_mip),
    .uir_i(uir), .incr_i(incr), .out_ir_o(out_ir), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_incr_o(out_incr), .out_micro_o(out_micro),
    .out_first_o(out_first), .out_last_o(out_last), .busy_o(busy), .irq_hold_o(irq_hold),
    .err_o(err)
  );

  thor2022_micro_sequencer #(.MIPW(7), .MAX_STEPS(16), .DROP_NOP(1'b1)) dut_dn (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_ir_i(in_ir), .in_valid_i(in_valid_dn),
    .in_ready_o(in_ready_dn), .micro_ipo(micro_ip_dn), .micro_ir_o(micro_ir_dn),
    .next_mip_i(next_mip_dn), .uir_i(uir_dn), .incr_i(incr_dn), .out_ir_o(out_ir_dn),
    .out_valid_o(out_valid_dn), .out_ready_i(out_ready), .out_incr_o(out_incr_dn),
    .out_micro_o(out_micro_dn), .out_first_o(out_first_dn), .out_last_o(out_last_dn),
    .busy_o(busy_dn), .irq_hold_o(irq_hold_dn), .err_o(err_dn)
  );

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid_dn = 1'b0;
    out_ready = 1'b1; in_ir = '0; rom_loop = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_micro, out_first, out_last, busy, err, irq_hold} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000",
                         {out_valid, out_micro, out_first, out_last, busy, err, irq_hold});
    end
    checks++;
    if ({micro_ip, micro_ir, out_ir, out_incr} !== '0) begin
      errors++; $display("FAIL reset_regs: got mip=%h mir=%h oir=%h incr=%h expected all 0",
                         micro_ip, micro_ir, out_ir, out_incr);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_pop;
    logic [47:0] ins;
    ins = mk(c_OPC_POP, 5);
    @(negedge clk); in_ir = ins; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({busy, in_ready, out_valid, micro_ip, micro_ir} !== {3'b100, 7'd1, ins}) begin
      errors++; $display("FAIL pop_seq_start: got busy=%b rdy=%b ov=%b mip=%0d mir=%h expected 1 0 0 1 %h",
                         busy, in_ready, out_valid, micro_ip, micro_ir, ins);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ir, out_first, out_last, out_micro, out_incr, busy, in_ready, irq_hold}
        !== {1'b1, mk(c_OPC_LDH, 1), 3'b101, 4'd2, 3'b101}) begin
      errors++; $display("FAIL pop_op1: got ov=%b ir=%h flm=%b%b%b incr=%0d busy=%b rdy=%b irq=%b",
                         out_valid, out_ir, out_first, out_last, out_micro, out_incr, busy, in_ready, irq_hold);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_ir, out_first, out_last, out_micro, out_incr, busy, in_ready, irq_hold}
        !== {1'b1, mk(c_OPC_ADDI, 2), 3'b011, 4'd2, 3'b010}) begin
      errors++; $display("FAIL pop_op2: got ov=%b ir=%h flm=%b%b%b incr=%0d busy=%b rdy=%b irq=%b",
                         out_valid, out_ir, out_first, out_last, out_micro, out_incr, busy, in_ready, irq_hold);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_drain: got ov=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); in_ir = mk(c_OPC_ADD, 100); in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_ir, out_micro, out_first, out_last, out_incr, in_ready}
          !== {1'b1, mk(c_OPC_ADD, 100 + i), 3'b000, 4'd0, 1'b1}) begin
        errors++; $display("FAIL b2b_add%0d: got ov=%b ir=%h mfl=%b%b%b incr=%0d rdy=%b expected ir=%h",
                           i, out_valid, out_ir, out_micro, out_first, out_last, out_incr, in_ready,
                           mk(c_OPC_ADD, 100 + i));
      end
      if (i < 2) in_ir = mk(c_OPC_ADD, 101 + i);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got ov=%b expected 0", out_valid); end
  endtask

  task automatic test_stall;
    logic [47:0] exp_ir [5];
    logic [3:0]  exp_inc [5];
    int idx, stalls, cyc;
    for (int k = 0; k < 4; k++) begin exp_ir[k] = mk(c_OPC_STH, 15 + k); exp_inc[k] = 4'd1; end
    exp_ir[4] = mk(c_OPC_ADDI, 19); exp_inc[4] = 4'd4;
    idx = 0; stalls = 0; cyc = 0;
    @(negedge clk); in_ir = mk(c_OPC_PUSHN, 4); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    while (idx < 5 && cyc < 30) begin
      cyc++;
      if (out_valid) begin
        if (idx == 1 && stalls < 2) begin out_ready = 1'b0; stalls++; end
        else out_ready = 1'b1;
        checks++;
        if ({out_ir, out_incr, out_first, out_last, irq_hold}
            !== {exp_ir[idx], exp_inc[idx], idx == 0, idx == 4, idx != 4}) begin
          errors++; $display("FAIL stall_op%0d: got ir=%h incr=%0d fl=%b%b irq=%b expected ir=%h incr=%0d",
                             idx, out_ir, out_incr, out_first, out_last, irq_hold, exp_ir[idx], exp_inc[idx]);
        end
        if (out_ready) idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (idx != 5 || stalls != 2) begin
      errors++; $display("FAIL stall_count: got ops=%0d stalls=%0d expected 5 2", idx, stalls);
    end
    checks++;
    if ({out_valid, busy, irq_hold} !== 3'b000) begin
      errors++; $display("FAIL stall_end: got ov/busy/irq=%b expected 000", {out_valid, busy, irq_hold});
    end
  endtask

  task automatic test_unknown_mip;
    @(negedge clk); in_ir = mk(c_OPC_PUSH, 3); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_ir, out_first, out_last, out_micro} !== {1'b1, mk(c_OPC_NOP, 0), 3'b111}) begin
      errors++; $display("FAIL unknown_mip_op: got ov=%b ir=%h flm=%b%b%b expected NOP 111",
                         out_valid, out_ir, out_first, out_last, out_micro);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL unknown_mip_end: got ov/busy=%b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_drop_nop;
    logic [47:0] exp0 [5];
    logic [47:0] exp1 [3];
    int n0, n1;
    exp0[0] = mk(c_OPC_LDH, 5); exp0[1] = mk(c_OPC_NOP, 6); exp0[2] = mk(c_OPC_LDH, 7);
    exp0[3] = mk(c_OPC_NOP, 8); exp0[4] = mk(c_OPC_ADDI, 9);
    exp1[0] = mk(c_OPC_LDH, 5); exp1[1] = mk(c_OPC_LDH, 7); exp1[2] = mk(c_OPC_ADDI, 9);
    n0 = 0; n1 = 0;
    @(negedge clk); in_ir = mk(c_OPC_POPN, 2); in_valid = 1'b1; in_valid_dn = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_valid_dn = 1'b0;
    repeat (12) begin
      if (out_valid && n0 < 5) begin
        checks++;
        if ({out_ir, out_first, out_last} !== {exp0[n0], n0 == 0, n0 == 4}) begin
          errors++; $display("FAIL keepnop_op%0d: got ir=%h fl=%b%b expected ir=%h",
                             n0, out_ir, out_first, out_last, exp0[n0]);
        end
      end
      if (out_valid) n0++;
      if (out_valid_dn && n1 < 3) begin
        checks++;
        if ({out_ir_dn, out_first_dn, out_last_dn} !== {exp1[n1], n1 == 0, n1 == 2}) begin
          errors++; $display("FAIL dropnop_op%0d: got ir=%h fl=%b%b expected ir=%h",
                             n1, out_ir_dn, out_first_dn, out_last_dn, exp1[n1]);
        end
      end
      if (out_valid_dn) n1++;
      @(negedge clk);
    end
    checks++;
    if (n0 != 5 || n1 != 3) begin
      errors++; $display("FAIL dropnop_count: got keep=%0d drop=%0d expected 5 3", n0, n1);
    end
  endtask

  task automatic test_flush;
    @(negedge clk); in_ir = mk(c_OPC_ENTER, 0); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_ir} !== {1'b1, mk(c_OPC_STH, 34)}) begin
      errors++; $display("FAIL flush_op3: got ov=%b ir=%h expected 1 %h", out_valid, out_ir, mk(c_OPC_STH, 34));
    end
    flush = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if ({out_valid, busy, micro_ip, in_ready, err} !== {2'b00, 7'd0, 2'b10}) begin
      errors++; $display("FAIL flush_state: got ov=%b busy=%b mip=%0d rdy=%b err=%b expected 0 0 0 1 0",
                         out_valid, busy, micro_ip, in_ready, err);
    end
    in_ir = mk(c_OPC_ADD, 200); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if ({out_valid, out_ir, out_micro, busy} !== {1'b1, mk(c_OPC_ADD, 200), 2'b00}) begin
      errors++; $display("FAIL flush_then_add: got ov=%b ir=%h micro=%b busy=%b", out_valid, out_ir, out_micro, busy);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL flush_no_resume: got ov/busy=%b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_watchdog;
    logic [47:0] exp_ir;
    int n;
    bit seen_last;
    n = 0; seen_last = 1'b0;
    rom_loop = 1'b1;
    @(negedge clk); in_ir = mk(c_OPC_POPN, 9); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 40 && !seen_last; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n++;
        exp_ir = (n % 2 == 1) ? mk(c_OPC_LDH, 5) : mk(c_OPC_SUBI, 6);
        checks++;
        if ({out_ir, out_first, out_last, err} !== {exp_ir, n == 1, n == 16, n == 16}) begin
          errors++; $display("FAIL wdog_op%0d: got ir=%h fl=%b%b err=%b expected ir=%h",
                             n, out_ir, out_first, out_last, err, exp_ir);
        end
        if (out_last) seen_last = 1'b1;
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL wdog_count: got %0d ops expected 16", n); end
    @(negedge clk);
    checks++;
    if ({err, busy, out_valid, micro_ip} !== {3'b000, 7'd0}) begin
      errors++; $display("FAIL wdog_end: got err=%b busy=%b ov=%b mip=%0d expected 0 0 0 0",
                         err, busy, out_valid, micro_ip);
    end
    rom_loop = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk); in_ir = mk(c_OPC_ENTER, 1); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, err, irq_hold, out_first, out_last, out_micro, micro_ip, micro_ir, out_ir, out_incr} !== '0) begin
      errors++; $display("FAIL async_reset: got ov=%b busy=%b mip=%0d mir=%h oir=%h expected all 0",
                         out_valid, busy, micro_ip, micro_ir, out_ir);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, micro_ip} !== {2'b00, 7'd0}) begin
      errors++; $display("FAIL async_reset_after: got ov=%b busy=%b mip=%0d expected 0 0 0",
                         out_valid, busy, micro_ip);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pop();
    test_back_to_back();
    test_stall();
    test_unknown_mip();
    test_drop_nop();
    test_flush();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
